// File: rtl/baud_gen_if.sv
// -----------------------------------------------------------------------------
// baud_gen_if
//
// Bundles the SPART I/O bus signals that reach the baud-rate generator
// together with the two strobes the generator produces.
//
//   IOCS     chip select, driven by the bus master
//   IORW     1 = read, 0 = write, driven by the bus master
//   IOADDR   register select, driven by the bus master
//   DB       write data byte, driven by the bus master
//   Enable   16x-oversample tick, driven by the generator
//   TxEnable 1x bit-rate tick, driven by the generator
//
// Modports:
//   master : processor / bus side (drives the bus, observes the strobes)
//   slave  : baud_gen side (observes the bus, drives the strobes)
// -----------------------------------------------------------------------------
interface baud_gen_if;
   logic       IOCS;
   logic       IORW;
   logic [1:0] IOADDR;
   logic [7:0] DB;
   logic       Enable;
   logic       TxEnable;

   modport master (
      output IOCS,
      output IORW,
      output IOADDR,
      output DB,
      input  Enable,
      input  TxEnable
   );

   modport slave (
      input  IOCS,
      input  IORW,
      input  IOADDR,
      input  DB,
      output Enable,
      output TxEnable
   );
endinterface

// File: rtl/baud_gen.sv
// -----------------------------------------------------------------------------
// baud_gen
//
// Programmable baud-rate tick generator for the SPART. A 16-bit down counter
// reloaded from the active divisor produces a one-cycle Enable strobe every
// (divisor + 1) clocks for the 16x-oversampling receiver. A 4-bit counter of
// Enable pulses produces TxEnable on every 16th Enable for the transmitter.
//
// The divisor is written as two bytes over the I/O bus: the low byte is only
// staged, and the high-byte write commits {high, staged low} atomically and
// restarts the period from scratch.
//
// Ports:
//   clk  : system clock, rising-edge active
//   rst  : asynchronous, active-high reset
//   bus  : baud_gen_if.slave
//            IOCS/IORW/IOADDR/DB in  -> divisor programming
//            Enable/TxEnable     out -> registered one-cycle strobes
//
// Parameters:
//   DEFAULT_DIV : divisor loaded at reset (162 -> 38400 baud x16 at 100 MHz)
// -----------------------------------------------------------------------------
module baud_gen #(
   parameter logic [15:0] DEFAULT_DIV = 16'd162
) (
   input  logic       clk,
   input  logic       rst,
   baud_gen_if.slave  bus
);

   localparam logic [1:0] ADDR_DIV_LO = 2'b10;
   localparam logic [1:0] ADDR_DIV_HI = 2'b11;

   // Architectural state
   logic [15:0] divisor_q, divisor_d;
   logic [7:0]  div_lo_q,  div_lo_d;
   logic [15:0] count_q,   count_d;
   logic [3:0]  tick_q,    tick_d;
   logic        enable_q,  enable_d;
   logic        tx_en_q,   tx_en_d;

   // Bus decode
   logic        bus_wr;
   logic        wr_lo;
   logic        wr_commit;
   logic        terminal;

   assign bus_wr    = bus.IOCS & ~bus.IORW;
   assign wr_lo     = bus_wr & (bus.IOADDR == ADDR_DIV_LO);
   assign wr_commit = bus_wr & (bus.IOADDR == ADDR_DIV_HI);
   assign terminal  = (count_q == 16'h0000);

   // Next-state logic
   always_comb begin
      divisor_d = divisor_q;
      div_lo_d  = div_lo_q;
      count_d   = count_q;
      tick_d    = tick_q;
      enable_d  = 1'b0;
      tx_en_d   = 1'b0;

      // Staging the low byte never touches the running period, even when it
      // lands on a terminal-count edge.
      if (wr_lo) begin
         div_lo_d = bus.DB;
      end

      if (wr_commit) begin
         // Commit wins over terminal count: the pending pulse is dropped and
         // the new period starts counting from this edge. The staged low
         // byte is the one held before this edge.
         divisor_d = {bus.DB, div_lo_q};
         count_d   = {bus.DB, div_lo_q};
         tick_d    = 4'h0;
      end else if (terminal) begin
         enable_d  = 1'b1;
         count_d   = divisor_q;
         tick_d    = tick_q + 4'd1;
         // TxEnable marks the Enable whose pre-increment tick was 15, i.e.
         // the 16th Enable after reset or commit.
         tx_en_d   = (tick_q == 4'hF);
      end else begin
         count_d   = count_q - 16'd1;
      end
   end

   // State registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         divisor_q <= DEFAULT_DIV;
         div_lo_q  <= 8'h00;
         count_q   <= DEFAULT_DIV;
         tick_q    <= 4'h0;
         enable_q  <= 1'b0;
         tx_en_q   <= 1'b0;
      end else begin
         divisor_q <= divisor_d;
         div_lo_q  <= div_lo_d;
         count_q   <= count_d;
         tick_q    <= tick_d;
         enable_q  <= enable_d;
         tx_en_q   <= tx_en_d;
      end
   end

   // Strobes come straight from flops: no input-to-output combinational path.
   assign bus.Enable   = enable_q;
   assign bus.TxEnable = tx_en_q;

endmodule

// File: tb/tb_baud_gen.sv
// -----------------------------------------------------------------------------
// tb_baud_gen
//
// Bench for baud_gen. Every bus operation that changes the rate pushes the
// expected Enable / TxEnable edge numbers onto scoreboard queues; a monitor
// on the falling edge pops and compares them every cycle.
// -----------------------------------------------------------------------------
module tb_baud_gen;

   localparam int OP_LO = 1;
   localparam int OP_HI = 2;
   localparam int OP_RD = 3;

   typedef struct {
      int         op;
      logic [7:0] db;
      int         period;   // expected Enable period after this operation
      int         run;      // cycles to observe afterwards
   } vec_t;

   logic clk;
   logic rst;
   int   edge_n;
   int   checks;
   int   errors;
   int   en_q[$];
   int   tx_q[$];
   vec_t tbl[14];

   baud_gen_if bus ();

   baud_gen #(
      .DEFAULT_DIV (16'd162)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Rising edges since reset was released; edge k is when the DUT updates.
   always @(posedge clk or posedge rst) begin
      if (rst) edge_n <= 0;
      else     edge_n <= edge_n + 1;
   end

   task automatic chk(input string name, input logic got, input logic exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at edge %0d: got %b, expected %b", name, edge_n, got, exp);
      end
   endtask

   // Replace the scoreboard with pulses of a new period starting at edge e0.
   task automatic predict(input int e0, input int p);
      int hz;
      hz = (2 * p > 12000) ? 2 * p : 12000;
      en_q.delete();
      tx_q.delete();
      for (int t = e0 + p; t <= e0 + hz; t += p) en_q.push_back(t);
      for (int t = e0 + 16 * p; t <= e0 + hz; t += 16 * p) tx_q.push_back(t);
   endtask

   // Monitor: one Enable and one TxEnable comparison every cycle.
   always @(negedge clk) begin
      bit en_exp;
      bit tx_exp;
      en_exp = (en_q.size() > 0) && (en_q[0] == edge_n);
      tx_exp = (tx_q.size() > 0) && (tx_q[0] == edge_n);
      if (en_exp) void'(en_q.pop_front());
      if (tx_exp) void'(tx_q.pop_front());
      chk("Enable", bus.Enable, en_exp);
      chk("TxEnable", bus.TxEnable, tx_exp);
   end

   task automatic sync();
      @(negedge clk);
      #2;
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
      #2;
   endtask

   // Called at negedge+2; the operation is sampled on the next rising edge.
   task automatic bus_op(input int op, input logic [7:0] db, input int p);
      bus.IOCS   = 1'b1;
      bus.IORW   = (op == OP_RD);
      bus.IOADDR = (op == OP_LO) ? 2'b10 : 2'b11;
      bus.DB     = db;
      if (op == OP_HI) predict(edge_n + 1, p);
      sync();
      bus.IOCS   = 1'b0;
      bus.IORW   = 1'b1;
      bus.IOADDR = 2'b00;
      bus.DB     = 8'h00;
   endtask

   initial begin
      bit found;

      tbl[0]  = '{OP_LO, 8'h04, 163,  20};
      tbl[1]  = '{OP_HI, 8'h00, 5,    200};
      tbl[2]  = '{OP_LO, 8'h02, 5,    50};
      tbl[3]  = '{OP_RD, 8'h00, 5,    30};
      tbl[4]  = '{OP_HI, 8'h00, 3,    100};
      tbl[5]  = '{OP_LO, 8'h00, 3,    5};
      tbl[6]  = '{OP_HI, 8'h00, 1,    64};
      tbl[7]  = '{OP_LO, 8'hFF, 1,    5};
      tbl[8]  = '{OP_HI, 8'h00, 256,  600};
      tbl[9]  = '{OP_LO, 8'h34, 256,  10};
      tbl[10] = '{OP_LO, 8'h56, 256,  10};
      tbl[11] = '{OP_HI, 8'h12, 4695, 5000};
      tbl[12] = '{OP_LO, 8'h04, 4695, 3};
      tbl[13] = '{OP_HI, 8'h00, 5,    100};

      checks     = 0;
      errors     = 0;
      bus.IOCS   = 1'b0;
      bus.IORW   = 1'b1;
      bus.IOADDR = 2'b00;
      bus.DB     = 8'h00;
      rst        = 1'b1;

      // Reset state, then the default rate (first Enable at 163, Tx at 2608)
      run(3);
      chk("reset_Enable", bus.Enable, 1'b0);
      chk("reset_TxEnable", bus.TxEnable, 1'b0);
      rst = 1'b0;
      predict(0, 163);
      run(2700);

      // Table-driven programming sequence
      for (int i = 0; i < 14; i++) begin
         bus_op(tbl[i].op, tbl[i].db, tbl[i].period);
         run(tbl[i].run);
      end

      // Commit landing exactly on a terminal-count edge (divisor stays 4)
      found = 1'b0;
      for (int i = 0; i < 20 && !found; i++) begin
         if (en_q.size() > 0 && en_q[0] == edge_n + 1) found = 1'b1;
         else sync();
      end
      chk("tc_commit_aligned", found, 1'b1);
      bus_op(OP_HI, 8'h00, 5);
      run(40);

      // Divisor 0, then asynchronous reset while Enable is high
      bus_op(OP_LO, 8'h00, 5);
      bus_op(OP_HI, 8'h00, 1);
      run(10);
      chk("en_before_rst", bus.Enable, 1'b1);
      rst = 1'b1;
      en_q.delete();
      tx_q.delete();
      #1;
      chk("async_rst_Enable", bus.Enable, 1'b0);
      chk("async_rst_TxEnable", bus.TxEnable, 1'b0);
      sync();
      rst = 1'b0;
      predict(0, 163);
      run(340);

      // Largest divisor: 65536-cycle period
      bus_op(OP_LO, 8'hFF, 163);
      bus_op(OP_HI, 8'hFF, 65536);
      run(65540);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/baud_gen.md
# baud_gen

Programmable baud-rate tick generator for the SPART. It produces the 16x-oversample `Enable` strobe consumed by the receive stage, and a 1x bit-rate `TxEnable` strobe for the transmit stage. The divisor is written by the processor through the SPART I/O bus as two bytes. It is committed atomically when the high byte is written.

## Interface
Parameters:
- `DEFAULT_DIV`, 16'd162: divisor loaded at reset (100 MHz clock, 38400 baud, 16x oversample).

Ports:
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `IOCS`  input  1  SPART chip select.
- `IORW`  input  1  1 = read, 0 = write.
- `IOADDR`  input  2  register select. 2'b10 = divisor low byte, 2'b11 = divisor high byte. 2'b00 and 2'b01 are ignored by this block.
- `DB`  input  8  write data from the bus.
- `Enable`  output  1  one-cycle 16x-oversample tick to the receiver.
- `TxEnable`  output  1  one-cycle bit-rate tick; coincides with every 16th `Enable`.

## Operation
State:
- `divisor[15:0]`: active divisor.
- `div_lo[7:0]`: staged low byte.
- `count[15:0]`: down counter.
- `tick[3:0]`: counts `Enable` pulses.
- `Enable` and `TxEnable` are registered outputs.

Reset (asynchronous):
- `divisor` = `count` = `DEFAULT_DIV`.
- `div_lo` = 8'h00, `tick` = 4'h0.
- `Enable` = 0, `TxEnable` = 0.

Bus decode, using the write condition `IOCS & ~IORW`:
- Write with `IOADDR` = 2'b10: `div_lo` <= `DB`. There is no other effect, and the rate does not change.
- Write with `IOADDR` = 2'b11 (commit): `divisor` <= {`DB`, `div_lo`}; `count` <= {`DB`, `div_lo`}; `tick` <= 0; `Enable` <= 0; `TxEnable` <= 0.
- Reads (`IORW` = 1) never alter state. Divisor readback is not supported.

Counting, on every edge with no commit:
- If `count` == 0: `Enable` <= 1; `count` <= `divisor`; `tick` <= `tick` + 1 (4-bit, wraps 15 -> 0); `TxEnable` <= (`tick` == 4'hF).
- Otherwise: `Enable` <= 0; `TxEnable` <= 0; `count` <= `count` - 1.

Arithmetic and boundary rules:
- All arithmetic is unsigned 16-bit. The counter never decrements below 0 because it is reloaded at terminal count.
- Divisor 16'h0000 is legal: `Enable` is high every cycle and `TxEnable` is high every 16th cycle.
- Divisor 16'hFFFF gives a period of 65536 cycles with no overflow.
- A commit on the same edge as terminal count takes precedence. That `Enable` is dropped and the new period starts.
- Writing the low byte twice before a commit means the last value wins.
- A low-byte write on a terminal-count edge does not disturb the tick.
- `rst` asserted mid-period restores the defaults immediately. No pulse is emitted during reset.

## Timing
- `Enable` period = `divisor` + 1 clock cycles. Each pulse is exactly one cycle wide.
- After `rst` deasserts, the first `Enable` is high following the (`DEFAULT_DIV` + 1)th rising edge.
- After a commit edge, the first `Enable` is high following the (new divisor + 1)th subsequent edge.
- `TxEnable` period = 16 x (`divisor` + 1) cycles. It is high in the same cycle as the `Enable` pulse whose pre-increment `tick` was 15. The first `TxEnable` after reset or commit therefore coincides with the 16th `Enable`.
- The receiver's sample point is determined solely by counting `Enable` pulses, so this block adds no data latency.
- There are no combinational paths from inputs to outputs.

## Test plan
- Reset, then run 2000 cycles with `DEFAULT_DIV` = 162 -> `Enable` rises first at cycle 163 and then every 163 cycles. `TxEnable` rises first at cycle 16 x 163 = 2608, so extend the run to 2700 cycles to observe it.
- Write `IOADDR` = 10 with `DB` = 8'h04, then `IOADDR` = 11 with `DB` = 8'h00 -> the commit clears both outputs. `Enable` then pulses every 5 cycles, and `TxEnable` pulses every 80 cycles in the same cycle as the 16th `Enable`.
- Write a low byte of 8'h02 only, with no commit -> the period stays unchanged. A later high-byte write of 8'h00 gives a period of 3.
- Commit a divisor of 0 -> `Enable` is high continuously and `TxEnable` is high 1 cycle in 16.
- Commit on the exact edge where `count` == 0 -> no `Enable` on that edge, and the next `Enable` follows after new divisor + 1 edges. A read (`IORW` = 1, `IOADDR` = 11) at any time leaves the period unaffected.
- Assert `rst` for 1 cycle mid-period, asynchronously between edges -> `Enable` and `TxEnable` go to 0 immediately and the divisor returns to 162. The first post-reset `Enable` arrives at cycle 163.
